thor2025_free_list: RTL and testbench

THOR2025_FREE_LIST -- requirements
Module: thor2025_free_list

---
 rtl/thor2025_pkg.sv | 18 +
 rtl/thor2025_free_compact.sv | 36 +++
 rtl/thor2025_free_list.sv | 126 ++++++++++++
 tb/tb_thor2025_free_list.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/thor2025_pkg.sv
// Thor2025 shared package.
// Holds the machine-wide register-renaming geometry (physical register count,
// physical tag width, architectural register width, free-list pointer width)
// plus small helpers used by the rename blocks.
package thor2025_pkg;

  localparam int NPREG      = 128;  // physical registers
  localparam int TAG_W      = 7;    // physical tag width
  localparam int AREG_W     = 6;    // architectural register index width
  localparam int PTR_W      = 8;    // free-list pointer: 7-bit index + wrap bit
  localparam int NFREE_PORT = 3;    // commit-side release ports

  // Number of set bits in a two-slot request vector.
  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/thor2025_free_compact.sv
// Thor2025 free-list release compactor.
// Packs the valid, nonzero release ports into consecutive buffer slots.
// Ports:
//   free_v   - per-port release valid
//   free_reg - per-port released tag
//   wen      - port actually writes (valid and tag != 0)
//   woff     - slot offset from tail for each writing port
//   total    - number of writing ports (tail advance)
module thor2025_free_compact #(
  parameter int NFREE_PORT = 3,
  parameter int TAG_W      = 7,
  parameter int OFF_W      = 2
) (
  input  logic [NFREE_PORT-1:0]            free_v,
  input  logic [NFREE_PORT-1:0][TAG_W-1:0] free_reg,
  output logic [NFREE_PORT-1:0]            wen,
  output logic [NFREE_PORT-1:0][OFF_W-1:0] woff,
  output logic [OFF_W-1:0]                 total
);

  logic [OFF_W-1:0] acc;

  // Tag 0 is the hard-wired zero register: it never enters the free list.
  always_comb begin
    acc  = '0;
    wen  = '0;
    woff = '0;
    for (int p = 0; p < NFREE_PORT; p++) begin
      wen[p]  = free_v[p] && (free_reg[p] != '0);
      woff[p] = acc;
      acc     = acc + OFF_W'(wen[p]);
    end
    total = acc;
  end

endmodule

// File: rtl/thor2025_free_list.sv
// Thor2025 physical-register free list.
// Circular buffer of free tags with a speculative head (allocation), a
// committed head (retirement) and a tail (release). A flush rewinds the
// speculative head to the committed head.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   flush                - branch-miss flush, rewinds speculative head
//   alloc_req[1:0]       - slot A / slot B want a destination tag
//   alloc_rega/alloc_regb- tags offered to slot A / slot B
//   alloc_rdy            - enough free tags for alloc_req
//   cmt_cnt[1:0]         - committing instructions with a destination
//   free_v / free_reg    - tags released at commit
//   count                - speculative free-tag count (tail - head)
//   err                  - sticky overflow / underflow flag
module thor2025_free_list #(
  parameter int NPREG      = thor2025_pkg::NPREG,
  parameter int NFREE_PORT = thor2025_pkg::NFREE_PORT
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic [1:0]                                    alloc_req,
  output logic [thor2025_pkg::TAG_W-1:0]                alloc_rega,
  output logic [thor2025_pkg::TAG_W-1:0]                alloc_regb,
  output logic                                          alloc_rdy,
  input  logic [1:0]                                    cmt_cnt,
  input  logic [NFREE_PORT-1:0]                         free_v,
  input  logic [NFREE_PORT-1:0][thor2025_pkg::TAG_W-1:0] free_reg,
  output logic [$clog2(NPREG):0]                        count,
  output logic                                          err
);

  import thor2025_pkg::*;

  localparam int IDX_W = $clog2(NPREG);
  localparam int PW    = IDX_W + 1;
  localparam int OFF_W = $clog2(NFREE_PORT + 1);

  logic [TAG_W-1:0] tags_q [NPREG];

  logic [PW-1:0] head_q, chead_q, tail_q;
  logic [PW-1:0] head_d, chead_d, tail_d;
  logic [PW-1:0] head_inc, live_d, spec_gap;
  logic          err_q, err_d;
  logic [1:0]    alloc_n;
  logic          alloc_ok;

  logic [NFREE_PORT-1:0]            wen;
  logic [NFREE_PORT-1:0][OFF_W-1:0] woff;
  logic [OFF_W-1:0]                 wtotal;
  logic [NFREE_PORT-1:0][PW-1:0]    widx;

  thor2025_free_compact #(
    .NFREE_PORT (NFREE_PORT),
    .TAG_W      (TAG_W),
    .OFF_W      (OFF_W)
  ) u_compact (
    .free_v   (free_v),
    .free_reg (free_reg),
    .wen      (wen),
    .woff     (woff),
    .total    (wtotal)
  );

  assign alloc_n   = popcnt2(alloc_req);
  assign count     = tail_q - head_q;
  assign alloc_rdy = (count >= PW'(alloc_n));
  assign alloc_ok  = alloc_rdy && !flush;
  assign head_inc  = head_q + PW'(1);

  // Slot B takes the next tag only when slot A is consuming the head one.
  assign alloc_rega = tags_q[head_q[IDX_W-1:0]];
  assign alloc_regb = alloc_req[0] ? tags_q[head_inc[IDX_W-1:0]]
                                   : tags_q[head_q[IDX_W-1:0]];

  always_comb begin
    chead_d = chead_q + PW'(cmt_cnt);
    head_d  = head_q;
    if (flush) begin
      head_d = chead_d;
    end else if (alloc_ok) begin
      head_d = head_q + PW'(alloc_n);
    end
    tail_d = tail_q + PW'(wtotal);
    for (int p = 0; p < NFREE_PORT; p++) begin
      widx[p] = tail_q + PW'(woff[p]);
    end
    // Live tags (free plus in flight) can never reach the full buffer size,
    // and commits can never overtake speculative allocation.
    live_d   = tail_d - chead_d;
    spec_gap = head_q - chead_d;
    err_d    = err_q;
    if ((wtotal != '0) && (live_d >= PW'(NPREG))) begin
      err_d = 1'b1;
    end
    if ((cmt_cnt != '0) && spec_gap[PW-1]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= PW'(NPREG - 1);
      err_q   <= 1'b0;
      // Tags 1..NPREG-1 start free; the last slot holds the unused zero tag.
      for (int i = 0; i < NPREG; i++) begin
        tags_q[i] <= (i == NPREG - 1) ? '0 : TAG_W'(i + 1);
      end
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
      for (int p = 0; p < NFREE_PORT; p++) begin
        if (wen[p]) begin
          tags_q[widx[p][IDX_W-1:0]] <= free_reg[p];
        end
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_thor2025_free_list.sv
// Testbench for thor2025_free_list: queue-based free-list model plus
// hand-computed directed expectations.
module tb_thor2025_free_list;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [1:0]      alloc_req, cmt_cnt;
  logic [6:0]      alloc_rega, alloc_regb;
  logic            alloc_rdy;
  logic [2:0]      free_v;
  logic [2:0][6:0] free_reg;
  logic [7:0]      count;
  logic            err;

  always #5 clk = ~clk;

  thor2025_free_list dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_req  (alloc_req),
    .alloc_rega (alloc_rega),
    .alloc_regb (alloc_regb),
    .alloc_rdy  (alloc_rdy),
    .cmt_cnt    (cmt_cnt),
    .free_v     (free_v),
    .free_reg   (free_reg),
    .count      (count),
    .err        (err)
  );

  int checks   = 0;
  int failures = 0;

  // Model: freeq = tags offered in order; allocd = allocated, not yet committed.
  int freeq[$];
  int allocd[$];
  bit m_err;
  bit chk_en = 1'b0;
  int need_c;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      need_c = int'(alloc_req[0]) + int'(alloc_req[1]);
      check("m_count", int'(count), freeq.size());
      check("m_err", int'(err), int'(m_err));
      check("m_alloc_rdy", int'(alloc_rdy), int'(freeq.size() >= need_c));
      if (freeq.size() >= 1) check("m_alloc_rega", int'(alloc_rega), freeq[0]);
      if (alloc_req[0] && freeq.size() >= 2)
        check("m_alloc_regb", int'(alloc_regb), freeq[1]);
      else if (!alloc_req[0] && freeq.size() >= 1)
        check("m_alloc_regb", int'(alloc_regb), freeq[0]);
    end
  end

  task automatic model_step();
    int n, nf;
    bit accept;
    if (rst) begin
      freeq.delete();
      allocd.delete();
      for (int t = 1; t < 128; t++) freeq.push_back(t);
      m_err = 1'b0;
      return;
    end
    n      = int'(alloc_req[0]) + int'(alloc_req[1]);
    accept = !flush && (freeq.size() >= n);
    if (int'(cmt_cnt) > allocd.size()) m_err = 1'b1;
    repeat (int'(cmt_cnt)) if (allocd.size() > 0) void'(allocd.pop_front());
    if (flush) begin
      for (int i = allocd.size() - 1; i >= 0; i--) freeq.push_front(allocd[i]);
      allocd.delete();
    end else if (accept) begin
      repeat (n) allocd.push_back(freeq.pop_front());
    end
    nf = 0;
    for (int p = 0; p < 3; p++) begin
      if (free_v[p] && free_reg[p] != 7'd0) begin
        freeq.push_back(int'(free_reg[p]));
        nf++;
      end
    end
    if (nf > 0 && (freeq.size() + allocd.size()) >= 128) m_err = 1'b1;
  endtask

  task automatic set_idle();
    alloc_req = 2'b00; cmt_cnt = 2'd0; flush = 1'b0;
    free_v = 3'b000; free_reg = '0;
  endtask

  task automatic step(input logic [1:0] rq, input int cm, input bit fl,
                      input logic [2:0] fv, input int r0, input int r1, input int r2);
    alloc_req = rq; cmt_cnt = cm[1:0]; flush = fl; free_v = fv;
    free_reg[0] = r0[6:0]; free_reg[1] = r1[6:0]; free_reg[2] = r2[6:0];
    @(posedge clk);
    model_step();
    #1;
    set_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2'b00, 0, 1'b0, 3'b000, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic peek(input logic [1:0] rq);
    alloc_req = rq;
    #1;
  endtask

  // Frees nfree tags drawn from a permutation of 1..127, three ports per
  // cycle, while slots allocate and one mid-stream flush rewinds.
  task automatic free_round(input int nfree, input int mul);
    int groups, idx, tg[3];
    logic [2:0] fv;
    logic [1:0] rq;
    groups = (nfree + 2) / 3;
    for (int g = 0; g < groups; g++) begin
      for (int j = 0; j < 3; j++) begin
        idx   = g * 3 + j;
        tg[j] = (idx < nfree) ? ((idx * mul) % 127) + 1 : 0;
      end
      fv = 3'b111;
      rq = (g % 3 == 1) ? 2'b11 : ((g % 3 == 2) ? 2'b01 : 2'b00);
      if (g == 5) step(rq, 1, 1'b1, fv, tg[0], tg[1], tg[2]);
      else        step(rq, 0, 1'b0, fv, tg[0], tg[1], tg[2]);
    end
  endtask

  task automatic commit_all();
    int c;
    while (allocd.size() > 0) begin
      c = (allocd.size() >= 3) ? 3 : allocd.size();
      step(2'b00, c, 1'b0, 3'b000, 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk_en = 1'b1;

    // Reset state and first dual allocation.
    check("rst_count", int'(count), 127);
    check("rst_err", int'(err), 0);
    peek(2'b11);
    check("rst_rega", int'(alloc_rega), 1);
    check("rst_regb", int'(alloc_regb), 2);
    check("rst_rdy", int'(alloc_rdy), 1);
    step(2'b11, 0, 1'b0, 3'b000, 0, 0, 0);
    check("dual_count", int'(count), 125);
    check("dual_rega", int'(alloc_rega), 3);

    // Slot B alone takes the head tag.
    do_reset();
    peek(2'b10);
    check("b_only_regb", int'(alloc_regb), 1);
    step(2'b10, 0, 1'b0, 3'b000, 0, 0, 0);
    check("b_only_count", int'(count), 126);
    check("b_only_rega", int'(alloc_rega), 2);

    // Drain every tag, then refuse further allocation.
    do_reset();
    repeat (63) step(2'b11, 0, 1'b0, 3'b000, 0, 0, 0);
    step(2'b01, 0, 1'b0, 3'b000, 0, 0, 0);
    check("empty_count", int'(count), 0);
    peek(2'b01);
    check("empty_rdy_a", int'(alloc_rdy), 0);
    peek(2'b11);
    check("empty_rdy_ab", int'(alloc_rdy), 0);
    step(2'b11, 0, 1'b0, 3'b000, 0, 0, 0);
    check("empty_hold", int'(count), 0);

    // Commit all, then two release rounds that wrap the pointers.
    commit_all();
    free_round(127, 37);
    commit_all();
    free_round(127 - freeq.size(), 53);
    commit_all();
    repeat (4) step(2'b11, 0, 1'b0, 3'b000, 0, 0, 0);
    check("wrap_err", int'(err), 0);

    // Flush with same-cycle commit rewinds to committed head.
    do_reset();
    repeat (3) step(2'b11, 0, 1'b0, 3'b000, 0, 0, 0);
    step(2'b11, 2, 1'b1, 3'b000, 0, 0, 0);
    check("flush_count", int'(count), 125);
    check("flush_rega", int'(alloc_rega), 3);
    check("flush_err", int'(err), 0);

    // Zero tag is dropped; 5 and 9 land at the tail in port order.
    do_reset();
    repeat (2) step(2'b11, 0, 1'b0, 3'b000, 0, 0, 0);
    step(2'b00, 3, 1'b0, 3'b000, 0, 0, 0);
    step(2'b00, 1, 1'b0, 3'b000, 0, 0, 0);
    step(2'b00, 0, 1'b0, 3'b111, 0, 5, 9);
    check("free_count", int'(count), 125);
    check("free_err", int'(err), 0);
    repeat (61) step(2'b11, 0, 1'b0, 3'b000, 0, 0, 0);
    step(2'b01, 0, 1'b0, 3'b000, 0, 0, 0);
    check("free_rega", int'(alloc_rega), 5);
    peek(2'b11);
    check("free_regb", int'(alloc_regb), 9);
    set_idle();

    // Release into a full list is an overflow; error is sticky until reset.
    do_reset();
    step(2'b00, 0, 1'b0, 3'b001, 7, 0, 0);
    check("ovf_err", int'(err), 1);
    repeat (3) step(2'b00, 0, 1'b0, 3'b000, 0, 0, 0);
    check("ovf_sticky", int'(err), 1);
    do_reset();
    check("ovf_clear", int'(err), 0);
    check("ovf_clear_count", int'(count), 127);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
